// File: rtl/quadrature_lock_detector.sv
// Quadrature lock detector.
// The block measures the period of a reference square wave (signal_in). It also
// measures the delay from each reference rising edge to the next rising edge of
// the lock-in output (signal_out). Lock is declared when 4*delay matches the
// period to within TOL cycles for LOCK_CNT consecutive periods. This is the
// condition for a 90 degree shift.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   reset      : asynchronous, active-high reset
//   signal_in  : reference square wave (asynchronous to clk)
//   signal_out : lock-in output, nominally 90 degrees behind signal_in
//   locked     : quadrature lock achieved
//   phase_err  : signed 4*delay - period of the last closed period
//   period     : last measured reference period in clk cycles
//   err_valid  : one-cycle pulse in the cycle period/phase_err/missing update
//   missing    : the last closed period contained no signal_out rising edge
//   timeout    : no reference edge for 2^CNT_W-1 cycles; cleared by next ref rise
//   fsm_state  : current FSM state (0 IDLE, 1 WAIT_Q, 2 WAIT_REF) for observation
//
// Handshake: the outputs are a pure pulse stream with no back-pressure.
// period, phase_err, missing and locked are stable from the err_valid cycle
// until the next err_valid pulse, a timeout, or a reset.
module quadrature_lock_detector #(
  parameter int CNT_W      = 16,
  parameter int TOL        = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signal_in,
  input  logic                    signal_out,
  output logic                    locked,
  output logic signed [CNT_W+2:0] phase_err,
  output logic [CNT_W-1:0]        period,
  output logic                    err_valid,
  output logic                    missing,
  output logic                    timeout,
  output logic [1:0]              fsm_state
);

  localparam int PE_W = CNT_W + 3;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(UNLOCK_CNT + 1);

  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic signed [PE_W-1:0] PE_MIN   = {1'b1, {(PE_W-1){1'b0}}};
  localparam logic signed [PE_W-1:0] TOL_HI   = PE_W'(TOL);
  localparam logic signed [PE_W-1:0] TOL_LO   = -TOL_HI;
  localparam logic [GW-1:0]          GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [BW-1:0]          BAD_MAX  = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_Q   = 2'd1,
    WAIT_REF = 2'd2
  } state_t;

  state_t state, next_state;

  logic ref_s1, ref_s2, ref_d;
  logic q_s1, q_s2, q_d;
  logic ref_rise, q_rise;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] delay;
  logic [GW-1:0]    good_run;
  logic [BW-1:0]    bad_run;

  logic                   close_period;
  logic                   tmo_hit;
  logic                   good;
  logic signed [PE_W-1:0] pe_calc;
  logic [GW-1:0]          good_next;
  logic [BW-1:0]          bad_next;

  // Two-flop synchronizers followed by a rising-edge detector. Both paths
  // are built the same way, so a coincident input edge stays coincident.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_d  <= 1'b0;
      q_s1   <= 1'b0;
      q_s2   <= 1'b0;
      q_d    <= 1'b0;
    end else begin
      ref_s1 <= signal_in;
      ref_s2 <= ref_s1;
      ref_d  <= ref_s2;
      q_s1   <= signal_out;
      q_s2   <= q_s1;
      q_d    <= q_s2;
    end
  end

  assign ref_rise  = ref_s2 & ~ref_d;
  assign q_rise    = q_s2 & ~q_d;
  assign fsm_state = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. A ref rise opens a new period. A q rise in the same
  // cycle belongs to that new period, so the FSM goes straight to WAIT_REF.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ref_rise) next_state = q_rise ? WAIT_REF : WAIT_Q;
      end
      WAIT_Q: begin
        if (ref_rise)     next_state = q_rise ? WAIT_REF : WAIT_Q;
        else if (tmo_hit) next_state = IDLE;
        else if (q_rise)  next_state = WAIT_REF;
      end
      WAIT_REF: begin
        if (ref_rise)     next_state = q_rise ? WAIT_REF : WAIT_Q;
        else if (tmo_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output and decode logic
  always_comb begin
    close_period = ref_rise && (state != IDLE);
    // A ref rise in the same cycle takes priority over the timeout.
    tmo_hit      = !ref_rise && (state != IDLE) && (cnt == CNT_MAX);
    // 4*delay - period at full width: zero-extend both operands to PE_W.
    pe_calc      = $signed({1'b0, delay, 2'b00}) - $signed({3'b000, cnt});
    good         = (state == WAIT_REF) && (pe_calc >= TOL_LO) && (pe_calc <= TOL_HI);
    good_next    = (good_run == GOOD_MAX) ? good_run : good_run + GW'(1);
    bad_next     = (bad_run == BAD_MAX) ? bad_run : bad_run + BW'(1);
  end

  // Measurement datapath and lock bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      delay     <= '0;
      period    <= '0;
      phase_err <= '0;
      missing   <= 1'b0;
      err_valid <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
    end else begin
      err_valid <= close_period;

      // cnt saturates at CNT_MAX and never wraps.
      if (ref_rise)
        cnt <= CNT_W'(1);
      else if ((state != IDLE) && (cnt != CNT_MAX))
        cnt <= cnt + CNT_W'(1);

      if (ref_rise && q_rise)
        delay <= '0;
      else if (q_rise && (state == WAIT_Q))
        delay <= cnt;

      if (close_period) begin
        period    <= cnt;
        missing   <= (state == WAIT_Q);
        phase_err <= (state == WAIT_Q) ? PE_MIN : pe_calc;
        if (good) begin
          good_run <= good_next;
          bad_run  <= '0;
          if (good_next == GOOD_MAX) locked <= 1'b1;
        end else begin
          bad_run  <= bad_next;
          good_run <= '0;
          if (bad_next == BAD_MAX) locked <= 1'b0;
        end
      end

      if (ref_rise) begin
        timeout <= 1'b0;
      end else if (tmo_hit) begin
        timeout  <= 1'b1;
        locked   <= 1'b0;
        good_run <= '0;
        bad_run  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_lock_detector.sv
module tb_quadrature_lock_detector;

  localparam int CNT_W      = 16;
  localparam int TOL        = 4;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 2;
  localparam int PE_W       = CNT_W + 3;
  localparam int EW         = 2 + PE_W + CNT_W;
  localparam int TMO_CYC    = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   signal_in;
  logic                   signal_out;
  logic                   locked;
  logic signed [PE_W-1:0] phase_err;
  logic [CNT_W-1:0]       period;
  logic                   err_valid;
  logic                   missing;
  logic                   timeout;
  logic [1:0]             fsm_state;

  quadrature_lock_detector #(
    .CNT_W(CNT_W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk(clk), .reset(reset), .signal_in(signal_in), .signal_out(signal_out),
    .locked(locked), .phase_err(phase_err), .period(period),
    .err_valid(err_valid), .missing(missing), .timeout(timeout),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry {locked, missing, phase_err, period} per closed period
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ev_count = 0;
  int last_ev_cyc = 0;

  // Reference model state: the period in progress and the lock run lengths
  bit m_active = 0;
  int m_p = 0;
  int m_d = 0;
  bit m_q = 0;
  int good_m = 0;
  int bad_m = 0;
  bit locked_m = 0;

  function automatic void model_clear();
    m_active = 0;
    good_m   = 0;
    bad_m    = 0;
    locked_m = 0;
  endfunction

  // Close the period in progress (if any) and predict what the DUT reports.
  function automatic void model_ref_rise(input int p, input int d, input bit qen);
    logic signed [PE_W-1:0] pe;
    int pe_i;
    bit good;
    if (m_active) begin
      pe_i = m_q ? (4 * m_d - m_p) : -(1 << (PE_W - 1));
      pe   = PE_W'(pe_i);
      good = m_q && (pe_i >= -TOL) && (pe_i <= TOL);
      if (good) begin
        bad_m = 0;
        if (good_m < LOCK_CNT) good_m++;
        if (good_m == LOCK_CNT) locked_m = 1;
      end else begin
        good_m = 0;
        if (bad_m < UNLOCK_CNT) bad_m++;
        if (bad_m == UNLOCK_CNT) locked_m = 0;
      end
      exp_q.push_back({locked_m, !m_q, pe, CNT_W'(m_p)});
    end
    m_active = 1;
    m_p = p;
    m_d = d;
    m_q = qen;
  endfunction

  // Advance one clock; sample #1 after the edge and score any err_valid.
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (err_valid === 1'b1) begin
      ev_count++;
      last_ev_cyc = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_err_valid cyc=%0d got period=%0d pe=%0d expected no pulse",
                 cyc, period, phase_err);
      end else begin
        e = exp_q.pop_front();
        if (period !== e[CNT_W-1:0]) begin
          n_err++;
          $display("FAIL sb_period cyc=%0d got %0d expected %0d", cyc, period, e[CNT_W-1:0]);
        end
        n_vec++;
        if (phase_err !== e[PE_W+CNT_W-1:CNT_W]) begin
          n_err++;
          $display("FAIL sb_phase_err cyc=%0d got %0d expected %0d", cyc, phase_err,
                   $signed(e[PE_W+CNT_W-1:CNT_W]));
        end
        n_vec++;
        if (missing !== e[EW-2]) begin
          n_err++;
          $display("FAIL sb_missing cyc=%0d got %0b expected %0b", cyc, missing, e[EW-2]);
        end
        n_vec++;
        if (locked !== e[EW-1]) begin
          n_err++;
          $display("FAIL sb_locked cyc=%0d got %0b expected %0b", cyc, locked, e[EW-1]);
        end
      end
    end
  endtask

  // Driver: one reference period of p cycles. signal_out rises d cycles
  // after signal_in and is high for p/2 cycles, or stays low when qen=0.
  task automatic drive_period(input int p, input int d, input bit qen);
    for (int c = 0; c < p; c++) begin
      if (c == 0) model_ref_rise(p, d, qen);
      signal_in  = (c < p / 2);
      signal_out = qen && (c >= d) && (c < d + p / 2);
      tick();
    end
  endtask

  task automatic drive_idle(input int n);
    signal_in  = 1'b0;
    signal_out = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if ({locked, phase_err, period, err_valid, missing, timeout, fsm_state} !== '0) begin
      n_err++;
      $display("FAIL %s got locked=%b pe=%0d period=%0d ev=%b miss=%b tmo=%b st=%0d expected all 0",
               tag, locked, phase_err, period, err_valid, missing, timeout, fsm_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    signal_in = 1'b0;
    signal_out = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    drive_idle(3);
    n_vec++;
    if (err_valid !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got ev=%b locked=%b expected 0 0", err_valid, locked);
    end
  endtask

  // 64-cycle period, 16-cycle delay: lock on the 8th err_valid.
  task automatic test_lock();
    int ev0;
    ev0 = ev_count;
    for (int i = 0; i < 8; i++) drive_period(64, 16, 1);
    n_vec++;
    if (locked !== 1'b0 || ev_count - ev0 !== 7) begin
      n_err++;
      $display("FAIL lock_early got locked=%b evs=%0d expected 0 7", locked, ev_count - ev0);
    end
    drive_period(64, 16, 1);
    n_vec++;
    if (locked !== 1'b1 || period !== 16'd64 || phase_err !== 19'sd0) begin
      n_err++;
      $display("FAIL lock_8th got locked=%b period=%0d pe=%0d expected 1 64 0",
               locked, period, phase_err);
    end
  endtask

  // Delay moved to 20 while locked: two bad periods drop lock.
  task automatic test_unlock();
    drive_period(64, 20, 1);
    drive_period(64, 20, 1);
    n_vec++;
    if (locked !== 1'b1 || phase_err !== 19'sd16) begin
      n_err++;
      $display("FAIL unlock_first_bad got locked=%b pe=%0d expected 1 16", locked, phase_err);
    end
    drive_period(64, 20, 1);
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL unlock_second_bad got locked=%b expected 0", locked);
    end
  endtask

  // Tolerance edges: -12, +12, -16 are bad; +4 is good.
  task automatic test_boundary();
    drive_period(64, 13, 1);
    drive_period(64, 19, 1);
    drive_period(64, 12, 1);
    drive_period(64, 17, 1);
    drive_period(64, 16, 1);
    n_vec++;
    if (phase_err !== 19'sd4 || missing !== 1'b0) begin
      n_err++;
      $display("FAIL boundary_plus4 got pe=%0d miss=%b expected 4 0", phase_err, missing);
    end
  endtask

  // A period without any q rise, then a coincident ref/q rise.
  task automatic test_missing();
    logic signed [PE_W-1:0] pe_min;
    pe_min = {1'b1, {(PE_W-1){1'b0}}};
    drive_period(64, 0, 0);
    drive_period(64, 0, 1);
    n_vec++;
    if (missing !== 1'b1 || phase_err !== pe_min) begin
      n_err++;
      $display("FAIL missing_period got miss=%b pe=%0d expected 1 %0d", missing, phase_err, pe_min);
    end
    drive_period(64, 16, 1);
    n_vec++;
    if (missing !== 1'b0 || phase_err !== -19'sd64) begin
      n_err++;
      $display("FAIL coincident_edge got miss=%b pe=%0d expected 0 -64", missing, phase_err);
    end
  endtask

  task automatic test_random();
    int p, d, r;
    bit qen;
    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(40, 120);
      r = $urandom_range(0, 7);
      qen = (r != 0);
      if (r < 5) d = p / 4 + $urandom_range(0, 2 * TOL + 2) - (TOL + 1);
      else       d = $urandom_range(0, p / 2 - 1);
      if (d < 0) d = 0;
      drive_period(p, d, qen);
    end
  endtask

  // Asynchronous reset mid-period while locked, then relock from scratch.
  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) drive_period(64, 16, 1);
    drive_idle(10);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    model_clear();
    drive_idle(3);
    for (int i = 0; i < 8; i++) drive_period(64, 16, 1);
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL relock_early got locked=%b expected 0", locked);
    end
    drive_period(64, 16, 1);
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL relock_8th got locked=%b expected 1", locked);
    end
  endtask

  // Reference stops while locked: timeout exactly 2^CNT_W-1 cycles later.
  task automatic test_timeout();
    bit prev_locked;
    bit seen;
    int ev0;
    drive_period(64, 16, 1);
    signal_in = 1'b0;
    signal_out = 1'b0;
    seen = 0;
    prev_locked = locked;
    for (int i = 0; i < TMO_CYC + 200; i++) begin
      prev_locked = locked;
      tick();
      if (timeout === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL timeout_wait got no timeout expected timeout after %0d cycles", TMO_CYC);
    end else begin
      n_vec++;
      if (cyc - last_ev_cyc !== TMO_CYC) begin
        n_err++;
        $display("FAIL timeout_time got %0d expected %0d", cyc - last_ev_cyc, TMO_CYC);
      end
      n_vec++;
      if (prev_locked !== 1'b1 || locked !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_unlock got before=%b after=%b expected 1 0", prev_locked, locked);
      end
    end
    model_clear();
    ev0 = ev_count;
    drive_period(64, 16, 1);
    n_vec++;
    if (timeout !== 1'b0 || ev_count !== ev0) begin
      n_err++;
      $display("FAIL timeout_clear got tmo=%b evs=%0d expected 0 0", timeout, ev_count - ev0);
    end
    drive_period(64, 16, 1);
    drive_idle(8);
  endtask

  initial begin
    reset = 1'b1;
    signal_in = 1'b0;
    signal_out = 1'b0;
    test_reset();
    test_lock();
    test_unlock();
    test_boundary();
    test_missing();
    test_random();
    test_reset_mid();
    test_timeout();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quadrature_lock_detector.md
QUADRATURE_LOCK_DETECTOR -- requirements
Module: quadrature_lock_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period/delay counters.
REQ-002 SHALL have parameter TOL, default 4: maximum allowed |phase_err| in clk cycles for a good period.
REQ-003 SHALL have parameter LOCK_CNT, default 8: number of consecutive good periods needed to assert locked.
REQ-004 SHALL have parameter UNLOCK_CNT, default 2: number of consecutive bad periods needed to deassert locked.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port signal_in, input, 1: reference square wave, the same signal that feeds the lock-in amplifier.
REQ-008 SHALL have port signal_out, input, 1: the lock-in amplifier output, nominally shifted 90 degrees.
REQ-009 SHALL have port locked, output, 1: quadrature lock achieved.
REQ-010 SHALL have port phase_err, output, CNT_W+3, signed: equals 4*delay - period.
REQ-011 SHALL have port period, output, CNT_W: last measured reference period in cycles.
REQ-012 SHALL have port err_valid, output, 1: one-cycle pulse when phase_err and period update.
REQ-013 SHALL have port missing, output, 1: the last period had no signal_out rising edge.
REQ-014 SHALL have port timeout, output, 1: no reference edge within 2^CNT_W-1 cycles.

Function
REQ-015 SHALL pass signal_in and signal_out each through a 2-flop synchronizer, then a rising-edge detector; both paths SHALL have identical latency.
REQ-016 SHALL implement states IDLE, WAIT_Q and WAIT_REF:
- IDLE: waits for the first ref rise.
- WAIT_Q: ref rise seen; waiting for a q (signal_out) rise.
- WAIT_REF: q rise seen; waiting for the next ref rise.
REQ-017 Counter behaviour:
- cnt SHALL load 1 in the cycle after a ref rise, then increment by 1 per cycle.
- period measured at the next ref rise SHALL equal cnt at that edge, i.e. the cycles between the two ref rises.
REQ-018 Delay capture:
- On a q rise in WAIT_Q, delay SHALL capture cnt and the state SHALL go to WAIT_REF.
- Further q rises in WAIT_REF SHALL be ignored.
REQ-019 On a ref rise in WAIT_Q or WAIT_REF, the block SHALL register period, phase_err and missing, and SHALL pulse err_valid exactly one cycle later.
- From IDLE, a ref rise SHALL go to WAIT_Q with no err_valid.
REQ-020 A ref rise in WAIT_Q (no q rise in the period) SHALL:
- set missing=1;
- set phase_err to the most negative representable value;
- count as a bad period;
- leave the state in WAIT_Q.
REQ-021 Coincident ref rise and q rise in the same cycle:
- The ref rise SHALL close the old period.
- The q rise SHALL belong to the new period with delay=0, and the state SHALL go to WAIT_REF.
REQ-022 phase_err SHALL be computed at full width CNT_W+3 with no overflow; the good/bad test is |phase_err| <= TOL.
REQ-023 Lock counter:
- A good period SHALL increment good_run (saturating at LOCK_CNT) and clear bad_run.
- A bad period SHALL increment bad_run (saturating at UNLOCK_CNT) and clear good_run.
REQ-024 locked SHALL set when good_run reaches LOCK_CNT and SHALL clear when bad_run reaches UNLOCK_CNT; both updates SHALL occur in the err_valid cycle.
REQ-025 If cnt reaches 2^CNT_W-1 in WAIT_Q or WAIT_REF, the block SHALL:
- assert timeout;
- clear locked, good_run and bad_run;
- go to IDLE.
- cnt SHALL saturate and never wrap.
REQ-026 timeout SHALL stay high until the next ref rise, which clears it.

Reset
REQ-027 While reset is high, all of the following SHALL be 0 and the state SHALL be IDLE: locked, phase_err, period, err_valid, missing, timeout, cnt, delay, good_run, bad_run and the synchronizers.
REQ-028 Assertion of reset mid-period SHALL abort the measurement with no err_valid; after release, the first ref rise only starts a new period.

Verification
REQ-029 Period 64, signal_out delayed 16 cycles: err_valid every 64 cycles with period=64, phase_err=0; locked rises in the 8th err_valid cycle.
REQ-030 Locked, then delay changed to 20: phase_err=+16, bad; locked falls on the 2nd consecutive bad err_valid.
REQ-031 Period 64, delays 13, then 19, then 12: phase_err = -12 (bad), +12 (bad), -16 (bad), with missing=0 throughout; then delay 17 gives phase_err=+4 (good, boundary).
REQ-032 signal_out held low for one period: missing=1 and phase_err=min for that period; a coincident ref/q rise then yields delay=0, i.e. phase_err=-64.
REQ-033 signal_in stopped while locked: timeout=1 and locked=0 exactly when cnt hits 65535; the next ref rise clears timeout without err_valid.
REQ-034 reset pulsed mid-period while locked: all outputs 0 immediately (asynchronous); relock requires 8 fresh good periods after the first ref rise.
